// File: rtl/health_alarm_pkg.sv
// Shared types and defaults for the health alarm controller.
// The default severity map assigns each sensor its warning level; 0 disables a sensor.
package health_alarm_pkg;

    // Alarm FSM: IDLE until a confirmed sensor arrives, ALARM until acknowledged
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ALARM = 1'b1
    } alarmStateT;

    localparam int DEFAULT_NUM_SENSORS = 6;
    localparam int DEFAULT_LEVEL_W     = 3;

    // Sensor i severity lives at [i*LEVEL_W +: LEVEL_W]; the leftmost entry is sensor 5
    localparam logic [DEFAULT_NUM_SENSORS*DEFAULT_LEVEL_W-1:0] DEFAULT_SEVERITY =
        {3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd3};

    // Default sensor map
    localparam int SENSOR_PRESSURE     = 0;
    localparam int SENSOR_BLOOD        = 1;
    localparam int SENSOR_FALL         = 2;
    localparam int SENSOR_TEMPERATURE  = 3;
    localparam int SENSOR_NERVOUS_LOW  = 4;
    localparam int SENSOR_NERVOUS_HIGH = 5;

endpackage

// File: rtl/persistence_filter.sv
// Confirms a raw abnormality flag only after it has been sampled high on
// PERSIST consecutive clock edges. Any low sample restarts the count.
module persistence_filter #(
    parameter int PERSIST = 3
) (
    input  logic clock,
    input  logic resetN,
    input  logic in,
    output logic confirmed
);

    localparam int CNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERSIST);

    logic [CNT_W-1:0] count;

    // Saturating run-length counter of consecutive high samples
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (!in) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    assign confirmed = (count == CNT_MAX);

endmodule

// File: rtl/health_alarm_controller.sv
// Latched, escalating warning controller. Each sensor flag is debounced by a
// persistence filter; the highest severity among confirmed sensors (lowest
// index on ties) drives a latched warning level that only acknowledge clears,
// and that steps up by one every ESC_CYCLES unacknowledged cycles.
module health_alarm_controller
    import health_alarm_pkg::*;
#(
    parameter int NUM_SENSORS = DEFAULT_NUM_SENSORS,
    parameter int LEVEL_W     = DEFAULT_LEVEL_W,
    parameter int PERSIST     = 3,
    parameter int ESC_CYCLES  = 16,
    parameter logic [NUM_SENSORS*LEVEL_W-1:0] SEVERITY = DEFAULT_SEVERITY
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic [NUM_SENSORS-1:0]         sensorAbnormal,
    input  logic                           acknowledge,
    output logic [LEVEL_W-1:0]             abnormalityWarning,
    output logic                           warningActive,
    output logic [$clog2(NUM_SENSORS)-1:0] sourceId,
    output logic                           escalated,
    output alarmStateT                     debugState
);

    localparam int ID_W  = $clog2(NUM_SENSORS);
    localparam int ESC_W = $clog2(ESC_CYCLES);
    localparam logic [ESC_W-1:0]   ESC_LAST  = ESC_W'(ESC_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

    logic [NUM_SENSORS-1:0] confirmed;
    logic [LEVEL_W-1:0]     curMax;
    logic [ID_W-1:0]        curId;
    logic                   curValid;
    alarmStateT             state;
    logic [ESC_W-1:0]       escCnt;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : gSensor
        persistence_filter #(
            .PERSIST(PERSIST)
        ) uFilter (
            .clock    (clock),
            .resetN   (resetN),
            .in       (sensorAbnormal[g]),
            .confirmed(confirmed[g])
        );
    end

    // Highest severity among confirmed sensors; strict compare keeps the lowest index on ties
    always_comb begin
        curMax = '0;
        curId  = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (confirmed[i] && (SEVERITY[i*LEVEL_W +: LEVEL_W] > curMax)) begin
                curMax = SEVERITY[i*LEVEL_W +: LEVEL_W];
                curId  = ID_W'(i);
            end
        end
    end

    assign curValid = (curMax != '0);

    // Alarm FSM with latched level, source and escalation timer
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state              <= IDLE;
            abnormalityWarning <= '0;
            sourceId           <= '0;
            escCnt             <= '0;
            escalated          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (curValid) begin
                        abnormalityWarning <= curMax;
                        sourceId           <= curId;
                        escCnt             <= '0;
                        escalated          <= 1'b0;
                        state              <= ALARM;
                    end
                end
                ALARM: begin
                    if (acknowledge && curValid) begin
                        // Acknowledge while still abnormal: restart from the current picture
                        abnormalityWarning <= curMax;
                        sourceId           <= curId;
                        escCnt             <= '0;
                        escalated          <= 1'b0;
                    end else if (acknowledge) begin
                        abnormalityWarning <= '0;
                        sourceId           <= '0;
                        escCnt             <= '0;
                        escalated          <= 1'b0;
                        state              <= IDLE;
                    end else if (curMax > abnormalityWarning) begin
                        // A worse sensor outranks a pending escalation step
                        abnormalityWarning <= curMax;
                        sourceId           <= curId;
                        escCnt             <= '0;
                    end else if (escCnt == ESC_LAST) begin
                        if (abnormalityWarning != LEVEL_MAX) begin
                            abnormalityWarning <= abnormalityWarning + 1'b1;
                        end
                        escCnt    <= '0;
                        escalated <= 1'b1;
                    end else begin
                        escCnt <= escCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign warningActive = (state == ALARM);
    assign debugState    = state;

endmodule

// File: doc/health_alarm_controller.md
# health_alarm_controller

Parametrised successor to the fixed five-input healthcare warning controller. It samples NUM_SENSORS single-bit abnormality flags and confirms each one only after it persists for PERSIST cycles. It reports the highest configured severity among confirmed sensors as a latched warning level, escalates an unacknowledged warning over time, and clears only on operator acknowledge. It sits between the sensor front-ends and the alert/display logic.

## Interface
- NUM_SENSORS, 6, number of abnormality inputs (≥2); default map: 0 pressure, 1 blood, 2 fall, 3 temperature, 4 nervous-low, 5 nervous-high
- LEVEL_W, 3, width of warning level
- PERSIST, 3, consecutive high samples needed to confirm a sensor (≥1)
- ESC_CYCLES, 16, cycles of unacknowledged alarm per escalation step (≥2)
- SEVERITY, {3'd6,3'd3,3'd2,3'd5,3'd4,3'd3}, packed NUM_SENSORS×LEVEL_W severity per sensor; sensor i at [i*LEVEL_W +: LEVEL_W]; 0 = ignore
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- sensorAbnormal  in  NUM_SENSORS  raw abnormality flags, synchronous to clock
- acknowledge  in  1  operator acknowledge, level-sampled, one cycle per ack
- abnormalityWarning  out  LEVEL_W  current warning level, 0 = none
- warningActive  out  1  high while FSM in ALARM
- sourceId  out  $clog2(NUM_SENSORS)  sensor that set current level
- escalated  out  1  high once ≥1 escalation step applied since last ack/entry

## Operation
- Per-sensor persistence counter, 0..PERSIST, saturating. Sample high: increment. Sample low: clear to 0. confirmed[i] = (count == PERSIST).
- curMax = max SEVERITY over confirmed sensors with nonzero severity; curId = lowest index achieving curMax. curValid = curMax ≠ 0.
- FSM states IDLE, ALARM.
- IDLE: outputs 0. If curValid: level←curMax, sourceId←curId, escCnt←0, escalated←0, go ALARM.
- ALARM, priority order:
  - acknowledge and curValid: level←curMax, sourceId←curId, escCnt←0, escalated←0; stay.
  - acknowledge and !curValid: clear all, go IDLE.
  - curMax > level: level←curMax, sourceId←curId, escCnt←0. Escalated is unchanged.
  - escCnt == ESC_CYCLES-1: level←min(level+1, 2^LEVEL_W−1), escCnt←0, escalated←1. sourceId is unchanged.
  - else escCnt←escCnt+1.
- Sensors dropping while in ALARM do not lower the level. The alarm is latched until acknowledge.
- Level never exceeds 2^LEVEL_W−1. Escalation at saturation keeps the level and sets escalated.

## Timing
- Reset (async assert, sync release on clock): all counters 0, FSM IDLE, abnormalityWarning 0, warningActive 0, sourceId 0, escalated 0.
- Reset asserted mid-alarm clears immediately, with no clock needed.
- Latency: sensor high on PERSIST consecutive rising edges → confirmed after edge PERSIST → outputs update after edge PERSIST+1.
- A sensor dropping for 1 sample before PERSIST restarts the count.
- acknowledge is acted on at the edge it is sampled. Outputs change after that same edge.
- A new higher confirmation and an escalation on the same edge: the higher curMax wins and escCnt clears.
- escCnt width is $clog2(ESC_CYCLES). First escalation occurs ESC_CYCLES edges after entering ALARM or after the last level reload.

## Structure
- Package health_alarm_pkg: FSM state enum (IDLE, ALARM), default LEVEL_W, default SEVERITY vector, sensor index constants.
- Sub-module persistence_filter (parameter PERSIST; ports clock, resetN, in, confirmed) is instantiated NUM_SENSORS times via generate.
- Top contains the max/priority reduction, FSM, and escalation counter.

## Test plan
- Reset mid-alarm: level 5 active, resetN low without a clock edge → all outputs 0 immediately; after release, all outputs stay 0 with inputs low.
- Persistence: sensor 2 (fall) high 2 cycles, low 1, high 3 → no warning after the first burst; warning 5, sourceId 2 after edge 4 of the second burst.
- Priority/tie: sensors 1 and 5 high together, with sensor 5 severity set equal to 4 via parameter → level 4, sourceId 1. With defaults → level 6, sourceId 5.
- Latch/raise: sensor 3 confirmed (level 2), then drops; sensor 0 confirmed → level 3, sourceId 0. Level never returns to 0 without ack.
- Escalation: sensor 1 held and no ack → level 4, then 5 after 16 cycles with escalated=1, then 6, 7, 7 (saturates).
- Acknowledge: ack with all sensors low → IDLE, outputs 0 next cycle. Ack with sensor 3 still confirmed at level 6 → level reloads to 2, escalated 0, warningActive stays 1.
